// File: rtl/mailbox_irq_ctrl_if.sv
// Mailbox interrupt controller bus: mailbox IRQ levels and mask in, core claim/complete
// handshake, presented interrupt and pending vector out.
interface mailbox_irq_ctrl_if #(
    parameter int NumMbox = 4,
    parameter int NumSrc  = 2 * NumMbox,
    parameter int IdWidth = $clog2(NumSrc)
);
    logic [NumMbox-1:0] snd_irq_i;
    logic [NumMbox-1:0] rcv_irq_i;
    logic [NumSrc-1:0]  mask_i;
    logic               claim_i;
    logic               complete_i;
    logic [IdWidth-1:0] complete_id_i;
    logic               irq_o;
    logic [IdWidth-1:0] irq_id_o;
    logic [NumSrc-1:0]  pending_o;

    modport master (
        output snd_irq_i, rcv_irq_i, mask_i, claim_i, complete_i, complete_id_i,
        input  irq_o, irq_id_o, pending_o
    );

    modport slave (
        input  snd_irq_i, rcv_irq_i, mask_i, claim_i, complete_i, complete_id_i,
        output irq_o, irq_id_o, pending_o
    );
endinterface

// File: rtl/mailbox_irq_ctrl.sv
// Edge-latching fixed-priority interrupt controller for the mailbox unit (claim/complete).
// Define MBOX_IRQ_SYNC_EN to add a 2-flop synchronizer per IRQ source before edge detection.
module mailbox_irq_ctrl_src (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic i_src,
    output logic o_rise
);
    logic w_src;
    logic r_prev;

`ifdef MBOX_IRQ_SYNC_EN
    logic [1:0] r_sync;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_sync <= '0;
        else         r_sync <= {r_sync[0], i_src};
    end
    assign w_src = r_sync[1];
`else
    assign w_src = i_src;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_prev <= 1'b0;
        else         r_prev <= w_src;
    end

    assign o_rise = w_src & ~r_prev;
endmodule

module mailbox_irq_ctrl #(
    parameter int NumMbox = 4,
    parameter int NumSrc  = 2 * NumMbox,
    parameter int IdWidth = $clog2(NumSrc)
) (
    input logic               clk_i,
    input logic               rst_ni,
    mailbox_irq_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, PRESENT, SERVICE} state_e;

    state_e             r_state;
    logic               r_irq;
    logic [IdWidth-1:0] r_irq_id;
    logic [NumSrc-1:0]  r_pending;

    logic [NumSrc-1:0]  w_src;
    logic [NumSrc-1:0]  w_rise;
    logic [NumSrc-1:0]  w_elig;
    logic [NumSrc-1:0]  w_clr;
    logic [IdWidth-1:0] w_win;
    logic               w_any;

    assign w_src = {bus.rcv_irq_i, bus.snd_irq_i};

    for (genvar g = 0; g < NumSrc; g++) begin : g_src
        mailbox_irq_ctrl_src u_src (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .i_src  (w_src[g]),
            .o_rise (w_rise[g])
        );
    end

    assign w_elig = r_pending & bus.mask_i;
    assign w_any  = |w_elig;

    // Scan high to low so the lowest eligible index is the last to win.
    always_comb begin
        w_win = '0;
        for (int i = NumSrc - 1; i >= 0; i--)
            if (w_elig[i]) w_win = IdWidth'(i);
    end

    always_comb begin
        w_clr = '0;
        if (r_state == PRESENT && bus.claim_i) w_clr[r_irq_id] = 1'b1;
    end

    // A rise in the same cycle as the claim re-pends the source.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_pending <= '0;
        else         r_pending <= (r_pending & ~w_clr) | w_rise;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= IDLE;
            r_irq    <= 1'b0;
            r_irq_id <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_irq_id <= w_win;
                        r_irq    <= 1'b1;
                        r_state  <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (bus.claim_i) begin
                        r_irq   <= 1'b0;
                        r_state <= SERVICE;
                    end else if (!bus.mask_i[r_irq_id]) begin
                        r_irq   <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                SERVICE: begin
                    if (bus.complete_i && bus.complete_id_i == r_irq_id) r_state <= IDLE;
                end
                default: begin
                    r_irq   <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.irq_o     = r_irq;
    assign bus.irq_id_o  = r_irq_id;
    assign bus.pending_o = r_pending;
endmodule

// File: tb/tb_mailbox_irq_ctrl.sv
// Directed bench for mailbox_irq_ctrl; latency follows MBOX_IRQ_SYNC_EN when defined.
module tb_mailbox_irq_ctrl;
`ifdef MBOX_IRQ_SYNC_EN
    localparam int S = 2;
`else
    localparam int S = 0;
`endif

    logic clk;
    logic rst_n;
    int   pas;
    int   tot;

    mailbox_irq_ctrl_if #(.NumMbox(4)) bus ();

    mailbox_irq_ctrl #(.NumMbox(4)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_inputs();
        bus.snd_irq_i     = '0;
        bus.rcv_irq_i     = '0;
        bus.mask_i        = 8'hFF;
        bus.claim_i       = 1'b0;
        bus.complete_i    = 1'b0;
        bus.complete_id_i = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        tick(2);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        bus.snd_irq_i[0] = 1'b1;
        tick(2);
        tot++; if (bus.irq_o !== 1'b0) $display("FAIL reset_irq got=%0b exp=0", bus.irq_o); else pas++;
        tot++; if (bus.irq_id_o !== 3'd0) $display("FAIL reset_id got=%0d exp=0", bus.irq_id_o); else pas++;
        tot++; if (bus.pending_o !== 8'h00) $display("FAIL reset_pend got=%h exp=00", bus.pending_o); else pas++;
        rst_n = 1'b1;
        tick(1 + S);
        tot++; if (bus.pending_o !== 8'h01) $display("FAIL reset_high_latch got=%h exp=01", bus.pending_o); else pas++;
        do_reset();
    endtask

    task automatic test_single();
        bus.rcv_irq_i[2] = 1'b1;
        tick(1 + S);
        tot++; if (bus.pending_o !== 8'h40) $display("FAIL single_pend got=%h exp=40", bus.pending_o); else pas++;
        tot++; if (bus.irq_o !== 1'b0) $display("FAIL single_lat_early got=%0b exp=0", bus.irq_o); else pas++;
        tick(1);
        tot++; if (bus.irq_o !== 1'b1) $display("FAIL single_irq got=%0b exp=1", bus.irq_o); else pas++;
        tot++; if (bus.irq_id_o !== 3'd6) $display("FAIL single_id got=%0d exp=6", bus.irq_id_o); else pas++;
        bus.claim_i = 1'b1;
        tick(1);
        bus.claim_i = 1'b0;
        tot++; if (bus.irq_o !== 1'b0) $display("FAIL single_claim_irq got=%0b exp=0", bus.irq_o); else pas++;
        tot++; if (bus.pending_o !== 8'h00) $display("FAIL single_claim_pend got=%h exp=00", bus.pending_o); else pas++;
        bus.complete_i = 1'b1; bus.complete_id_i = 3'd6;
        tick(1);
        bus.complete_i = 1'b0;
        bus.snd_irq_i[1] = 1'b1;
        tick(2 + S);
        tot++; if (bus.irq_o !== 1'b1 || bus.irq_id_o !== 3'd1)
            $display("FAIL single_idle_after_cpl got=%0b/%0d exp=1/1", bus.irq_o, bus.irq_id_o); else pas++;
        do_reset();
    endtask

    task automatic test_priority();
        bus.snd_irq_i[3] = 1'b1;
        tick(2 + S);
        tot++; if (bus.irq_id_o !== 3'd3) $display("FAIL prio_first got=%0d exp=3", bus.irq_id_o); else pas++;
        bus.snd_irq_i[0] = 1'b1;
        tick(1 + S);
        tot++; if (bus.pending_o !== 8'h09) $display("FAIL prio_pend got=%h exp=09", bus.pending_o); else pas++;
        tick(1);
        tot++; if (bus.irq_o !== 1'b1 || bus.irq_id_o !== 3'd3)
            $display("FAIL prio_hold got=%0b/%0d exp=1/3", bus.irq_o, bus.irq_id_o); else pas++;
        bus.claim_i = 1'b1;
        tick(1);
        bus.claim_i = 1'b0;
        tot++; if (bus.pending_o !== 8'h01) $display("FAIL prio_claim_pend got=%h exp=01", bus.pending_o); else pas++;
        bus.complete_i = 1'b1; bus.complete_id_i = 3'd3;
        tick(1);
        bus.complete_i = 1'b0;
        tot++; if (bus.irq_o !== 1'b0) $display("FAIL prio_gap got=%0b exp=0", bus.irq_o); else pas++;
        tick(1);
        tot++; if (bus.irq_o !== 1'b1 || bus.irq_id_o !== 3'd0)
            $display("FAIL prio_next got=%0b/%0d exp=1/0", bus.irq_o, bus.irq_id_o); else pas++;
        do_reset();
    endtask

    task automatic test_mask();
        bus.mask_i = 8'hFD;
        bus.snd_irq_i[1] = 1'b1;
        tick(1 + S);
        tot++; if (bus.pending_o !== 8'h02) $display("FAIL mask_pend got=%h exp=02", bus.pending_o); else pas++;
        tick(2);
        tot++; if (bus.irq_o !== 1'b0) $display("FAIL mask_gated got=%0b exp=0", bus.irq_o); else pas++;
        bus.mask_i = 8'hFF;
        tick(1);
        tot++; if (bus.irq_o !== 1'b1 || bus.irq_id_o !== 3'd1)
            $display("FAIL mask_enable got=%0b/%0d exp=1/1", bus.irq_o, bus.irq_id_o); else pas++;
        bus.mask_i = 8'hFD;
        tick(1);
        tot++; if (bus.irq_o !== 1'b0) $display("FAIL mask_withdraw got=%0b exp=0", bus.irq_o); else pas++;
        tot++; if (bus.pending_o !== 8'h02) $display("FAIL mask_keep_pend got=%h exp=02", bus.pending_o); else pas++;
        tick(1);
        tot++; if (bus.irq_o !== 1'b0) $display("FAIL mask_idle got=%0b exp=0", bus.irq_o); else pas++;
        do_reset();
    endtask

    task automatic test_errors();
        bus.mask_i = 8'hFB;
        bus.snd_irq_i[2] = 1'b1;
        tick(1 + S);
        bus.claim_i = 1'b1;
        tick(1);
        bus.claim_i = 1'b0;
        tot++; if (bus.pending_o !== 8'h04) $display("FAIL err_idle_claim got=%h exp=04", bus.pending_o); else pas++;
        tot++; if (bus.irq_o !== 1'b0) $display("FAIL err_idle_irq got=%0b exp=0", bus.irq_o); else pas++;
        bus.mask_i = 8'hFF;
        tick(1);
        tot++; if (bus.irq_o !== 1'b1 || bus.irq_id_o !== 3'd2)
            $display("FAIL err_present got=%0b/%0d exp=1/2", bus.irq_o, bus.irq_id_o); else pas++;
        bus.claim_i = 1'b1;
        tick(1);
        bus.claim_i = 1'b0;
        bus.snd_irq_i[0] = 1'b1;
        tick(1 + S);
        bus.complete_i = 1'b1; bus.complete_id_i = 3'd5;
        tick(1);
        bus.complete_i = 1'b0;
        tick(1);
        tot++; if (bus.irq_o !== 1'b0) $display("FAIL err_bad_cpl got=%0b exp=0", bus.irq_o); else pas++;
        tot++; if (bus.irq_id_o !== 3'd2) $display("FAIL err_bad_cpl_id got=%0d exp=2", bus.irq_id_o); else pas++;
        bus.complete_i = 1'b1; bus.complete_id_i = 3'd2;
        tick(1);
        bus.complete_i = 1'b0;
        tick(1);
        tot++; if (bus.irq_o !== 1'b1 || bus.irq_id_o !== 3'd0)
            $display("FAIL err_good_cpl got=%0b/%0d exp=1/0", bus.irq_o, bus.irq_id_o); else pas++;
        do_reset();
    endtask

    task automatic test_race();
        bus.rcv_irq_i[0] = 1'b1;
        tick(2 + S);
        tot++; if (bus.irq_o !== 1'b1 || bus.irq_id_o !== 3'd4)
            $display("FAIL race_present got=%0b/%0d exp=1/4", bus.irq_o, bus.irq_id_o); else pas++;
        bus.rcv_irq_i[0] = 1'b0;
        tick(1 + S);
        bus.rcv_irq_i[0] = 1'b1;
        tick(S);
        bus.claim_i = 1'b1;
        tick(1);
        bus.claim_i = 1'b0;
        tot++; if (bus.pending_o !== 8'h10) $display("FAIL race_set_wins got=%h exp=10", bus.pending_o); else pas++;
        tot++; if (bus.irq_o !== 1'b0) $display("FAIL race_service got=%0b exp=0", bus.irq_o); else pas++;
        tick(2);
        tot++; if (bus.irq_o !== 1'b0) $display("FAIL race_hold_svc got=%0b exp=0", bus.irq_o); else pas++;
        bus.complete_i = 1'b1; bus.complete_id_i = 3'd4;
        tick(1);
        bus.complete_i = 1'b0;
        tick(1);
        tot++; if (bus.irq_o !== 1'b1 || bus.irq_id_o !== 3'd4)
            $display("FAIL race_repres got=%0b/%0d exp=1/4", bus.irq_o, bus.irq_id_o); else pas++;
        do_reset();
    endtask

    task automatic test_reset_mid();
        bus.snd_irq_i[2] = 1'b1;
        bus.snd_irq_i[1] = 1'b1;
        bus.mask_i = 8'hFB;
        tick(2 + S);
        bus.mask_i = 8'hFF;
        bus.claim_i = 1'b1;
        tick(1);
        bus.claim_i = 1'b0;
        tot++; if (bus.irq_id_o !== 3'd1 || bus.pending_o !== 8'h04)
            $display("FAIL rmid_setup got=%0d/%h exp=1/04", bus.irq_id_o, bus.pending_o); else pas++;
        #2 rst_n = 1'b0;
        #1;
        tot++; if (bus.irq_o !== 1'b0 || bus.irq_id_o !== 3'd0 || bus.pending_o !== 8'h00)
            $display("FAIL rmid_async got=%0b/%0d/%h exp=0/0/00", bus.irq_o, bus.irq_id_o, bus.pending_o); else pas++;
        do_reset();
        tick(3 + S);
        tot++; if (bus.irq_o !== 1'b0 || bus.pending_o !== 8'h00)
            $display("FAIL rmid_lost got=%0b/%h exp=0/00", bus.irq_o, bus.pending_o); else pas++;
    endtask

    initial begin
        pas = 0;
        tot = 0;
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_single();
        test_priority();
        test_mask();
        test_errors();
        test_race();
        test_reset_mid();
        $display("%0d/%0d checks passed", pas, tot);
        $finish;
    end
endmodule
